// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: opcodes, field positions, widths, FSM encoding.
package fetch_sequencer_pkg;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 21;
    localparam int CNT_W   = 8;
    localparam int OP_HI   = 20;
    localparam int OP_LO   = 17;
    localparam int OP_W    = OP_HI - OP_LO + 1;

    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OP_W-1:0] OP_LOAD = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
    import fetch_sequencer_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch FSM with valid/ready issue to execute and redirect support.
// Optional: define FETCH_JUMP_EN to make JMP load the PC from instruction[3:0].
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    program_counter,
    input  logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   issue_count
);

    state_e          state_q;
    state_e          state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            do_start;
    logic            accept;
    logic [OP_W-1:0] opcode;

    assign opcode = opcode_of(instruction);
    assign accept = (state_q == S_ISSUE) && instr_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        do_start = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    do_start = 1'b1;
                    pc_d     = '0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Redirect wins over halt and any sequential/jump update.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end else if (instr_ready) begin
                    if (opcode == OP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + 1'b1;
`ifdef FETCH_JUMP_EN
                        if (opcode == OP_JMP) begin
                            pc_d = instruction[PC_W-1:0];
                        end
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_issue_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (do_start),
        .inc  (accept),
        .count(issue_count)
    );

    assign program_counter = pc_q;
    assign instr_valid     = (state_q == S_ISSUE);
    assign instr_out       = instr_valid ? instruction : '0;
    assign busy            = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign halted          = (state_q == S_HALT);

endmodule
